// File: rtl/mips_ctrl_pkg.sv
// Shared control-bundle layout, register constants and ID/EX FSM encoding
// for the pipelined MIPS core.
package mips_ctrl_pkg;

  localparam int CTRL_WIDTH = 15;

  // Bit positions inside the decoder control bundle
  localparam int CTRL_JR        = 14;
  localparam int CTRL_JAL       = 13;
  localparam int CTRL_JUMP      = 12;
  localparam int CTRL_REGDST    = 11;
  localparam int CTRL_ALUSRC    = 10;
  localparam int CTRL_MEMTOREG  = 9;
  localparam int CTRL_REGWRITE  = 8;
  localparam int CTRL_MEMREAD   = 7;
  localparam int CTRL_MEMWRITE  = 6;
  localparam int CTRL_BNE       = 5;
  localparam int CTRL_BEQ       = 4;
  localparam int CTRL_ALUOP_MSB = 3;
  localparam int CTRL_ALUOP_LSB = 0;

  // Link register written by jal
  localparam logic [4:0] REG_RA = 5'd31;

  // ID/EX hazard FSM encoding
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_STALL_X = 1'b1;

  // Destination register: jal links to $ra, R-type writes rd, otherwise rt
  function automatic logic [4:0] dest_reg(input logic [CTRL_WIDTH-1:0] ctrl,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd);
    if (ctrl[CTRL_JAL])         return REG_RA;
    else if (ctrl[CTRL_REGDST]) return rd;
    else                        return rt;
  endfunction

endpackage

// File: rtl/mips_hazard_detect.sv
// Combinational hazard detector: compares the ID instruction's source
// registers against the destination of the instruction currently in EX.
import mips_ctrl_pkg::*;

module mips_hazard_detect (
  input  logic                  id_valid,
  input  logic [CTRL_WIDTH-1:0] id_control,
  input  logic [4:0]            id_rs,
  input  logic [4:0]            id_rt,
  input  logic                  ex_valid,
  input  logic [CTRL_WIDTH-1:0] ex_control,
  input  logic [4:0]            ex_write_reg,
  output logic                  load_use,
  output logic                  jr_hz,
  output logic                  jr_load
);

  logic uses_rs;
  logic uses_rt;
  logic ex_live;
  logic unused_ctrl;

  // Plain jumps and jal carry a target, not a register source
  assign uses_rs = id_valid & ~(id_control[CTRL_JUMP] & ~id_control[CTRL_JR])
                 & ~id_control[CTRL_JAL];
  assign uses_rt = id_valid & (id_control[CTRL_REGDST] | id_control[CTRL_MEMWRITE]
                 | id_control[CTRL_BEQ] | id_control[CTRL_BNE]);

  // $0 is hard-wired, so a producer targeting it never creates a hazard
  assign ex_live = ex_valid & (ex_write_reg != 5'd0);

  assign load_use = ex_live & ex_control[CTRL_MEMREAD]
                  & ((uses_rs & (ex_write_reg == id_rs))
                   | (uses_rt & (ex_write_reg == id_rt)));

  // jr resolves its target in ID, so even an ALU result is too late
  assign jr_hz   = id_valid & id_control[CTRL_JR] & ex_live
                 & ex_control[CTRL_REGWRITE] & (ex_write_reg == id_rs);
  assign jr_load = jr_hz & ex_control[CTRL_MEMREAD];

  assign unused_ctrl = ^{id_control[CTRL_ALUSRC], id_control[CTRL_MEMTOREG],
                         id_control[CTRL_REGWRITE], id_control[CTRL_MEMREAD],
                         id_control[CTRL_ALUOP_MSB:CTRL_ALUOP_LSB],
                         ex_control[CTRL_JR:CTRL_MEMTOREG],
                         ex_control[CTRL_MEMWRITE:CTRL_ALUOP_LSB]};

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / jr hazard bubbles, PC/IF-ID stall
// generation and a saturating bubble counter.
import mips_ctrl_pkg::*;

module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = mips_ctrl_pkg::CTRL_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CTRL_WIDTH-1:0] id_control,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic [DATA_WIDTH-1:0] id_pc_plus4,
  input  logic [DATA_WIDTH-1:0] id_read_data1,
  input  logic [DATA_WIDTH-1:0] id_read_data2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic                  flush,
  input  logic                  hold,
  output logic [CTRL_WIDTH-1:0] ex_control,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_pc_plus4,
  output logic [DATA_WIDTH-1:0] ex_read_data1,
  output logic [DATA_WIDTH-1:0] ex_read_data2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [4:0]            ex_rs,
  output logic [4:0]            ex_rt,
  output logic [4:0]            ex_rd,
  output logic [4:0]            ex_write_reg,
  output logic [4:0]            ex_shamt,
  output logic                  stall,
  output logic [15:0]           stall_cycles
);

  logic [4:0] id_rs, id_rt, id_rd, id_shamt, id_write_reg;
  logic       load_use, jr_hz, jr_load;
  logic       bubble;
  logic [0:0] state;
  logic       unused_instr;

  assign id_rs        = id_instr[25:21];
  assign id_rt        = id_instr[20:16];
  assign id_rd        = id_instr[15:11];
  assign id_shamt     = id_instr[10:6];
  assign id_write_reg = dest_reg(id_control, id_rt, id_rd);
  assign unused_instr = ^{id_instr[31:26], id_instr[5:0]};

  mips_hazard_detect u_hazard (
    .id_valid     (id_valid),
    .id_control   (id_control),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_valid     (ex_valid),
    .ex_control   (ex_control),
    .ex_write_reg (ex_write_reg),
    .load_use     (load_use),
    .jr_hz        (jr_hz),
    .jr_load      (jr_load)
  );

  // A bubble is owed in STALL_X or on any live hazard, unless a flush kills ID
  assign bubble = ~flush & ((state == ST_STALL_X) | load_use | jr_hz);

  // Stall request: hold freezes everything, a bubble keeps ID in place
  always_comb begin
    // NOTE: default assignment first so every path drives stall and no latch is inferred.
    stall = 1'b0;
    if (reset) begin
      if (hold)        stall = 1'b1;
      else if (bubble) stall = 1'b1;
    end
  end

  // Pipeline register, hazard FSM and bubble counter
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      // NOTE: data registers are reset too, since every EX output must read 0 out of reset.
      ex_control    <= '0;
      ex_valid      <= 1'b0;
      ex_pc_plus4   <= '0;
      ex_read_data1 <= '0;
      ex_read_data2 <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_write_reg  <= '0;
      ex_shamt      <= '0;
      state         <= ST_RUN;
      stall_cycles  <= '0;
    end else if (!hold) begin
      // Data fields follow ID on every non-held cycle; ex_valid qualifies them
      ex_pc_plus4   <= id_pc_plus4;
      ex_read_data1 <= id_read_data1;
      ex_read_data2 <= id_read_data2;
      ex_imm        <= id_imm;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      ex_write_reg  <= id_write_reg;
      ex_shamt      <= id_shamt;
      if (flush) begin
        ex_control <= '0;
        ex_valid   <= 1'b0;
        state      <= ST_RUN;
      end else if (bubble) begin
        ex_control <= '0;
        ex_valid   <= 1'b0;
        // jr after a load needs a second bubble until the load reaches WB
        state      <= ((state == ST_RUN) && jr_load) ? ST_STALL_X : ST_RUN;
        if (stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      end else begin
        ex_control <= id_control;
        ex_valid   <= id_valid;
        state      <= ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: each step drives ID, pushes the
// expected EX/stall result, clocks once and pops/compares.
module tb_id_ex_stage;

  localparam logic [14:0] C_ADD = 15'h0902;  // RegDst RegWrite ALUOp=2
  localparam logic [14:0] C_LW  = 15'h0780;  // ALUSrc MemtoReg RegWrite MemRead
  localparam logic [14:0] C_SW  = 15'h0440;  // ALUSrc MemWrite
  localparam logic [14:0] C_JR  = 15'h5000;  // Jr Jump
  localparam logic [14:0] C_JAL = 15'h3100;  // Jal Jump RegWrite

  // data modes for the registered data fields
  localparam int DM_NONE = 0, DM_LOAD = 1, DM_KEEP = 2, DM_ZERO = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] id_control;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4, id_read_data1, id_read_data2, id_imm;
  logic        flush, hold;
  logic [14:0] ex_control;
  logic        ex_valid;
  logic [31:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_write_reg, ex_shamt;
  logic        stall;
  logic [15:0] stall_cycles;

  id_ex_stage dut (
    .clk           (clk),
    .reset         (reset),
    .id_control    (id_control),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc_plus4   (id_pc_plus4),
    .id_read_data1 (id_read_data1),
    .id_read_data2 (id_read_data2),
    .id_imm        (id_imm),
    .flush         (flush),
    .hold          (hold),
    .ex_control    (ex_control),
    .ex_valid      (ex_valid),
    .ex_pc_plus4   (ex_pc_plus4),
    .ex_read_data1 (ex_read_data1),
    .ex_read_data2 (ex_read_data2),
    .ex_imm        (ex_imm),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd),
    .ex_write_reg  (ex_write_reg),
    .ex_shamt      (ex_shamt),
    .stall         (stall),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        valid;
    logic [14:0] ctrl;
    logic [4:0]  wr;
    logic [15:0] cyc;
    int          dm;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [4:0]  rs;
    logic [4:0]  shamt;
  } exp_t;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          seq    = 0;
  logic [31:0] last_pc, last_rd1;
  logic [4:0]  last_rs, last_shamt;

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd3, 6'd0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [14:0] c, input logic v, input logic [31:0] ins);
    id_control = c;
    id_valid   = v;
    id_instr   = ins;
  endtask

  // One clock: check stall before the edge, check EX registers after it
  task automatic step(input string tag, input logic s, input logic v,
                      input logic [14:0] c, input logic [4:0] w,
                      input logic [15:0] n, input int dm);
    exp_t e, g;
    seq++;
    id_pc_plus4   = 32'(seq) << 2;
    id_read_data1 = 32'hA000_0000 + 32'(seq);
    id_read_data2 = 32'hB000_0000 + 32'(seq);
    id_imm        = 32'(seq);
    e.tag = tag; e.valid = v; e.ctrl = c; e.wr = w; e.cyc = n; e.dm = dm;
    case (dm)
      DM_LOAD: begin
        last_pc = id_pc_plus4; last_rd1 = id_read_data1;
        last_rs = id_instr[25:21]; last_shamt = id_instr[10:6];
      end
      DM_ZERO: begin
        last_pc = '0; last_rd1 = '0; last_rs = '0; last_shamt = '0;
      end
      default: ;
    endcase
    e.pc = last_pc; e.rd1 = last_rd1; e.rs = last_rs; e.shamt = last_shamt;
    sb.push_back(e);
    #1;
    check({tag, "/stall"}, 32'(stall), 32'(s));
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check({g.tag, "/ex_valid"},     32'(ex_valid),     32'(g.valid));
    check({g.tag, "/ex_control"},   32'(ex_control),   32'(g.ctrl));
    check({g.tag, "/stall_cycles"}, 32'(stall_cycles), 32'(g.cyc));
    if (g.dm != DM_NONE) begin
      check({g.tag, "/ex_write_reg"},  32'(ex_write_reg),  32'(g.wr));
      check({g.tag, "/ex_pc_plus4"},   ex_pc_plus4,        g.pc);
      check({g.tag, "/ex_read_data1"}, ex_read_data1,      g.rd1);
      check({g.tag, "/ex_rs"},         32'(ex_rs),         32'(g.rs));
      check({g.tag, "/ex_shamt"},      32'(ex_shamt),      32'(g.shamt));
    end
  endtask

  task automatic fast(input logic [14:0] c, input logic [31:0] ins);
    drive(c, 1'b1, ins);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; hold = 1'b0;
    last_pc = '0; last_rd1 = '0; last_rs = '0; last_shamt = '0;

    // Reset with a load pending in ID: stall forced low, everything zero
    drive(C_LW, 1'b1, mk(29, 8, 0));
    step("reset", 0, 0, 15'h0, 5'd0, 16'd0, DM_ZERO);
    reset = 1'b1;

    // Load-use on rs: one bubble, then the add proceeds
    drive(C_LW, 1'b1, mk(29, 8, 0));   step("lw8",        0, 1, C_LW,  5'd8,  16'd0, DM_LOAD);
    drive(C_ADD, 1'b1, mk(8, 10, 9));  step("lu_bubble",  1, 0, 15'h0, 5'd9,  16'd1, DM_LOAD);
    step("lu_add",     0, 1, C_ADD, 5'd9,  16'd1, DM_LOAD);

    // $0 producer never stalls
    drive(C_LW, 1'b1, mk(29, 0, 0));   step("lw0",        0, 1, C_LW,  5'd0,  16'd1, DM_LOAD);
    drive(C_ADD, 1'b1, mk(0, 10, 9));  step("add_r0",     0, 1, C_ADD, 5'd9,  16'd1, DM_LOAD);

    // Store data (rt) after load
    drive(C_LW, 1'b1, mk(29, 8, 0));   step("lw8_b",      0, 1, C_LW,  5'd8,  16'd1, DM_LOAD);
    drive(C_SW, 1'b1, mk(29, 8, 0));   step("sw_bubble",  1, 0, 15'h0, 5'd8,  16'd2, DM_LOAD);
    step("sw",         0, 1, C_SW,  5'd8,  16'd2, DM_LOAD);

    // jr after ALU producer: one bubble
    drive(C_ADD, 1'b1, mk(1, 2, 8));   step("add8",       0, 1, C_ADD, 5'd8,  16'd2, DM_LOAD);
    drive(C_JR, 1'b1, mk(8, 0, 0));    step("jr_alu_bub", 1, 0, 15'h0, 5'd0,  16'd3, DM_LOAD);
    step("jr_alu",     0, 1, C_JR,  5'd0,  16'd3, DM_LOAD);

    // jr after load: two bubbles via STALL_X
    drive(C_LW, 1'b1, mk(29, 8, 0));   step("lw8_c",      0, 1, C_LW,  5'd8,  16'd3, DM_LOAD);
    drive(C_JR, 1'b1, mk(8, 0, 0));    step("jr_ld_bub1", 1, 0, 15'h0, 5'd0,  16'd4, DM_LOAD);
    step("jr_ld_bub2", 1, 0, 15'h0, 5'd0,  16'd5, DM_LOAD);
    step("jr_ld",      0, 1, C_JR,  5'd0,  16'd5, DM_LOAD);

    // jal links to $31 regardless of rd/rt
    drive(C_JAL, 1'b1, mk(0, 7, 5));   step("jal",        0, 1, C_JAL, 5'd31, 16'd5, DM_LOAD);

    // Flush during STALL_X: no stall, counter frozen, FSM back to RUN
    drive(C_LW, 1'b1, mk(29, 8, 0));   step("lw8_d",      0, 1, C_LW,  5'd8,  16'd5, DM_LOAD);
    drive(C_JR, 1'b1, mk(8, 0, 0));    step("jr_ld_bub3", 1, 0, 15'h0, 5'd0,  16'd6, DM_LOAD);
    flush = 1'b1;                      step("flush_sx",   0, 0, 15'h0, 5'd0,  16'd6, DM_NONE);
    flush = 1'b0;                      step("after_fl",   0, 1, C_JR,  5'd0,  16'd6, DM_LOAD);

    // Hold for three cycles: EX frozen, stall high
    drive(C_ADD, 1'b1, mk(1, 2, 9));   step("pre_hold",   0, 1, C_ADD, 5'd9,  16'd6, DM_LOAD);
    hold = 1'b1;
    drive(C_LW, 1'b1, mk(29, 8, 0));
    for (int i = 0; i < 3; i++) step("hold", 1, 1, C_ADD, 5'd9, 16'd6, DM_KEEP);
    hold = 1'b0;                       step("post_hold",  0, 1, C_LW,  5'd8,  16'd6, DM_LOAD);

    // Flush beats a load-use hazard
    flush = 1'b1;
    drive(C_ADD, 1'b1, mk(8, 10, 9));  step("flush_hz",   0, 0, 15'h0, 5'd0,  16'd6, DM_NONE);
    flush = 1'b0;

    // Reset in the middle of a load-use stall
    drive(C_LW, 1'b1, mk(29, 8, 0));   step("lw8_e",      0, 1, C_LW,  5'd8,  16'd6, DM_LOAD);
    drive(C_ADD, 1'b1, mk(8, 10, 9));
    reset = 1'b0;                      step("reset_mid",  0, 0, 15'h0, 5'd0,  16'd0, DM_ZERO);
    reset = 1'b1;

    // Counter saturation: lw + jr yields two bubbles per three cycles
    for (int i = 0; i < 32767; i++) begin
      fast(C_LW, mk(29, 8, 0));
      fast(C_JR, mk(8, 0, 0));
      fast(C_JR, mk(8, 0, 0));
    end
    drive(C_LW, 1'b1, mk(29, 8, 0));   step("sat_lw",     0, 1, C_LW,  5'd8,  16'hFFFE, DM_LOAD);
    drive(C_JR, 1'b1, mk(8, 0, 0));    step("sat_b1",     1, 0, 15'h0, 5'd0,  16'hFFFF, DM_LOAD);
    step("sat_b2",     1, 0, 15'h0, 5'd0,  16'hFFFF, DM_LOAD);
    drive(C_LW, 1'b1, mk(29, 8, 0));   step("sat_lw2",    0, 1, C_LW,  5'd8,  16'hFFFF, DM_LOAD);
    drive(C_JR, 1'b1, mk(8, 0, 0));    step("sat_b3",     1, 0, 15'h0, 5'd0,  16'hFFFF, DM_LOAD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
